// File: rtl/pipe_id_buf.sv
// pipe_id_buf: decode-front instruction buffer for the MIPS pipeline.
// A DEPTH-entry circular FIFO of {pc, instr} sits between IF and ID so that
// IF can keep fetching while ID stalls. The head entry's source registers are
// resolved against NFWD prioritised bypass sources (index 0 = youngest,
// highest priority). A winning source whose result is still pending stalls
// the head.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   if_validto, if_pc,       IF offer; accepted when id_allowin is high
//   if_instr, id_allowin
//   exe_allowin,             EXE handshake; the head pops when both are high
//   id_exe_validto
//   flush                    discards buffered and incoming entries
//   rsc, rtc / rs_rf, rt_rf  regfile read addresses and read data
//   fwd_valid, fwd_pending,  bypass sources, packed per source index
//   fwd_rdc, fwd_data
//   pc_out, instr_out        head entry
//   rs_out, rt_out           forwarded operands
//   stall                    head is blocked by a pending producer
//   count                    buffer occupancy
//   stall_cnt                saturating count of stall cycles
module pipe_id_buf #(
  parameter int DEPTH = 4,
  parameter int NFWD  = 3,
  parameter int CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         if_validto,
  input  logic [31:0]                  if_pc,
  input  logic [31:0]                  if_instr,
  output logic                         id_allowin,
  input  logic                         exe_allowin,
  output logic                         id_exe_validto,
  input  logic                         flush,
  output logic [4:0]                   rsc,
  output logic [4:0]                   rtc,
  input  logic [31:0]                  rs_rf,
  input  logic [31:0]                  rt_rf,
  input  logic [NFWD-1:0]              fwd_valid,
  input  logic [NFWD-1:0]              fwd_pending,
  input  logic [5*NFWD-1:0]            fwd_rdc,
  input  logic [32*NFWD-1:0]           fwd_data,
  output logic [31:0]                  pc_out,
  output logic [31:0]                  instr_out,
  output logic [31:0]                  rs_out,
  output logic [31:0]                  rt_out,
  output logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      pc_mem_d    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      instr_mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic        head_valid;
  logic        push;
  logic        pop;
  logic        haz_rs, haz_rt;
  logic [31:0] rs_fwd, rt_fwd;
  logic [31:0] head_instr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Head entry: visible one cycle after it was written; when empty the
  // outputs simply show whatever storage the read pointer addresses.
  assign head_instr = instr_mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign pc_out     = pc_mem_q[rd_ptr_q];
  assign instr_out  = head_instr;
  assign rsc        = head_instr[25:21];
  assign rtc        = head_instr[20:16];

  // Bypass resolution: scan from lowest priority upward so the
  // lowest-index matching source overrides everything below it, including
  // the pending flag of lower-priority matches.
  always_comb begin
    rs_fwd = rs_rf;
    rt_fwd = rt_rf;
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    for (int i = NFWD-1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rdc[5*i +: 5] != 5'd0)) begin
        if (fwd_rdc[5*i +: 5] == rsc) begin
          rs_fwd = fwd_data[32*i +: 32];
          haz_rs = fwd_pending[i];
        end
        if (fwd_rdc[5*i +: 5] == rtc) begin
          rt_fwd = fwd_data[32*i +: 32];
          haz_rt = fwd_pending[i];
        end
      end
    end
    // $0 reads as zero regardless of the regfile port.
    if (rsc == 5'd0) rs_fwd = '0;
    if (rtc == 5'd0) rt_fwd = '0;
  end

  assign rs_out         = rs_fwd;
  assign rt_out         = rt_fwd;
  assign stall          = head_valid & (haz_rs | haz_rt);
  assign pop            = head_valid & ~stall & exe_allowin & ~flush;
  // Combinational through exe_allowin: a full buffer still accepts a push
  // when the head leaves in the same cycle.
  assign id_allowin     = (count_q < OCC_W'(DEPTH)) | pop;
  assign push           = if_validto & id_allowin & ~flush;
  assign id_exe_validto = head_valid & ~stall & ~flush;
  assign count          = count_q;
  assign stall_cnt      = stall_cnt_q;

  always_comb begin
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]    = if_pc;
      instr_mem_d[wr_ptr_q] = if_instr;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Register boundary: buffer storage, pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_id_buf.sv
// Self-checking bench for pipe_id_buf: directed scenarios with literal
// expectations plus a randomized phase, all cross-checked every cycle
// against a queue-based reference model.
module tb_pipe_id_buf;

  localparam int DEPTH = 4;
  localparam int NFWD  = 3;
  localparam int CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                if_validto;
  logic [31:0]         if_pc, if_instr;
  logic                id_allowin;
  logic                exe_allowin;
  logic                id_exe_validto;
  logic                flush;
  logic [4:0]          rsc, rtc;
  logic [31:0]         rs_rf, rt_rf;
  logic [NFWD-1:0]     fwd_valid, fwd_pending;
  logic [5*NFWD-1:0]   fwd_rdc;
  logic [32*NFWD-1:0]  fwd_data;
  logic [31:0]         pc_out, instr_out, rs_out, rt_out;
  logic                stall;
  logic [2:0]          count;
  logic [CNT_W-1:0]    stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t             mq[$];
  logic [CNT_W-1:0] m_scnt;

  pipe_id_buf #(.DEPTH(DEPTH), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_validto(if_validto), .if_pc(if_pc), .if_instr(if_instr),
    .id_allowin(id_allowin), .exe_allowin(exe_allowin),
    .id_exe_validto(id_exe_validto), .flush(flush),
    .rsc(rsc), .rtc(rtc), .rs_rf(rs_rf), .rt_rf(rt_rf),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_rdc(fwd_rdc), .fwd_data(fwd_data),
    .pc_out(pc_out), .instr_out(instr_out),
    .rs_out(rs_out), .rt_out(rt_out),
    .stall(stall), .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand resolution from the forwarding rules: first matching source
  // in priority order decides; $0 is always zero.
  function automatic void resolve(input logic [4:0] r, input logic [31:0] rf,
                                  output logic [31:0] v, output logic h);
    v = rf;
    h = 1'b0;
    if (r == 5'd0) begin
      v = 32'h0;
      return;
    end
    for (int i = 0; i < NFWD; i++) begin
      if (fwd_valid[i] && fwd_rdc[5*i +: 5] == r) begin
        if (fwd_pending[i]) h = 1'b1;
        else v = fwd_data[32*i +: 32];
        return;
      end
    end
  endfunction

  function automatic void model_eval(output logic hv, output logic st, output logic alw,
                                     output logic vld, output logic psh, output logic pp,
                                     output logic hrs, output logic hrt,
                                     output logic [31:0] vrs, output logic [31:0] vrt);
    logic [31:0] ins;
    hv  = (mq.size() != 0);
    ins = hv ? mq[0].instr : 32'h0;
    resolve(ins[25:21], rs_rf, vrs, hrs);
    resolve(ins[20:16], rt_rf, vrt, hrt);
    st  = hv && (hrs || hrt);
    pp  = hv && !st && exe_allowin && !flush;
    alw = (mq.size() < DEPTH) || pp;
    vld = hv && !st && !flush;
    psh = if_validto && alw && !flush;
  endfunction

  // Reference model state update.
  always @(posedge clk or negedge rst_n) begin
    logic hv, st, alw, vld, psh, pp, hrs, hrt;
    logic [31:0] vrs, vrt;
    if (!rst_n) begin
      mq.delete();
      m_scnt <= '0;
    end else begin
      model_eval(hv, st, alw, vld, psh, pp, hrs, hrt, vrs, vrt);
      if (st && m_scnt != 4'hF) m_scnt <= m_scnt + 4'd1;
      if (flush) mq.delete();
      else begin
        if (pp) void'(mq.pop_front());
        if (psh) mq.push_back('{if_pc, if_instr});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic hv, st, alw, vld, psh, pp, hrs, hrt;
    logic [31:0] vrs, vrt;
    model_eval(hv, st, alw, vld, psh, pp, hrs, hrt, vrs, vrt);
    chk("m_validto", 32'(id_exe_validto), 32'(vld));
    chk("m_allowin", 32'(id_allowin), 32'(alw));
    chk("m_stall",   32'(stall), 32'(st));
    chk("m_count",   32'(count), 32'(mq.size()));
    chk("m_stallcnt", 32'(stall_cnt), 32'(m_scnt));
    if (hv) begin
      chk("m_pc",    pc_out, mq[0].pc);
      chk("m_instr", instr_out, mq[0].instr);
      chk("m_rsc",   32'(rsc), 32'(mq[0].instr[25:21]));
      chk("m_rtc",   32'(rtc), 32'(mq[0].instr[20:16]));
      if (!hrs) chk("m_rs_out", rs_out, vrs);
      if (!hrt) chk("m_rt_out", rt_out, vrt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_validto  = 1'b0;
    if_pc       = 32'h0;
    if_instr    = 32'h0;
    exe_allowin = 1'b0;
    flush       = 1'b0;
    rs_rf       = 32'h0;
    rt_rf       = 32'h0;
    fwd_valid   = '0;
    fwd_pending = '0;
    fwd_rdc     = '0;
    fwd_data    = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_validto", 32'(id_exe_validto), 32'h0);
    chk("rst_stall",   32'(stall), 32'h0);
    chk("rst_allowin", 32'(id_allowin), 32'h1);
    chk("rst_pc",      pc_out, 32'h0);
    chk("rst_instr",   instr_out, 32'h0);
    chk("rst_rsc",     32'(rsc), 32'h0);
    chk("rst_rtc",     32'(rtc), 32'h0);
    chk("rst_rs_out",  rs_out, 32'h0);
    chk("rst_rt_out",  rt_out, 32'h0);
    chk("rst_count",   32'(count), 32'h0);
    rst_n = 1'b1;
    step();

    // Fill to full with EXE blocked, hold the 5th offer, then drain in order.
    if_validto = 1'b1;
    for (int n = 0; n < 5; n++) begin
      if_pc    = 32'h00400000 + 32'(4*n);
      if_instr = 32'(n);
      #1;
      chk(n == 4 ? "full_allowin" : "fill_allowin", 32'(id_allowin), (n == 4) ? 32'h0 : 32'h1);
      step();
    end
    chk("full_count", 32'(count), 32'd4);
    step();
    chk("hold_count", 32'(count), 32'd4);
    exe_allowin = 1'b1;
    #1;
    chk("drain_pc0",      pc_out, 32'h00400000);
    chk("drain_allowin",  32'(id_allowin), 32'h1);
    step();
    if_validto = 1'b0;
    chk("full_pop_push_count", 32'(count), 32'd4);
    for (int k = 1; k < 5; k++) begin
      #1;
      chk("drain_pc",    pc_out, 32'h00400000 + 32'(4*k));
      chk("drain_instr", instr_out, 32'(k));
      step();
    end
    chk("drained_count", 32'(count), 32'd0);
    exe_allowin = 1'b0;

    // Priority: sources 0 and 2 both hit $1; source 0 wins.
    if_validto = 1'b1;
    if_pc      = 32'h00400100;
    if_instr   = 32'h00221820;
    fwd_valid  = 3'b101;
    fwd_rdc    = {5'd1, 5'd0, 5'd1};
    fwd_data   = {32'h22, 32'h0, 32'h11};
    rs_rf      = 32'hDEAD;
    rt_rf      = 32'h5;
    step();
    if_validto = 1'b0;
    #1;
    chk("prio_rs_out",  rs_out, 32'h11);
    chk("prio_rt_out",  rt_out, 32'h5);
    chk("prio_validto", 32'(id_exe_validto), 32'h1);
    chk("prio_rsc",     32'(rsc), 32'd1);
    exe_allowin = 1'b1;
    step();
    exe_allowin = 1'b0;
    chk("prio_popped", 32'(count), 32'd0);

    // Pending producer of $4 for two cycles, then forwarded value.
    fwd_valid   = 3'b001;
    fwd_rdc     = {5'd0, 5'd0, 5'd4};
    fwd_pending = 3'b001;
    fwd_data    = '0;
    exe_allowin = 1'b1;
    if_validto  = 1'b1;
    if_pc       = 32'h00400200;
    if_instr    = 32'h00800020;
    step();
    if_validto = 1'b0;
    #1;
    chk("haz_stall1",   32'(stall), 32'h1);
    chk("haz_validto1", 32'(id_exe_validto), 32'h0);
    step();
    chk("haz_stall2",   32'(stall), 32'h1);
    chk("haz_cnt1",     32'(stall_cnt), 32'd1);
    step();
    fwd_pending = 3'b000;
    fwd_data    = {64'h0, 32'h99};
    #1;
    chk("haz_released", 32'(stall), 32'h0);
    chk("haz_rs_out",   rs_out, 32'h99);
    chk("haz_validto",  32'(id_exe_validto), 32'h1);
    chk("haz_cnt2",     32'(stall_cnt), 32'd2);
    step();
    chk("haz_popped",   32'(count), 32'd0);
    exe_allowin = 1'b0;

    // $0 source with a pending producer aimed at $0: no hazard.
    fwd_valid   = 3'b001;
    fwd_rdc     = '0;
    fwd_pending = 3'b001;
    rs_rf       = 32'h1234;
    if_validto  = 1'b1;
    if_instr    = 32'h00000020;
    step();
    if_validto = 1'b0;
    #1;
    chk("r0_stall",   32'(stall), 32'h0);
    chk("r0_rs_out",  rs_out, 32'h0);
    chk("r0_validto", 32'(id_exe_validto), 32'h1);
    exe_allowin = 1'b1;
    step();
    idle_inputs();

    // Flush with 3 buffered entries and a concurrent offer.
    if_validto = 1'b1;
    for (int n = 0; n < 3; n++) begin
      if_pc    = 32'h00400300 + 32'(4*n);
      if_instr = 32'h00000020;
      step();
    end
    chk("pre_flush_count", 32'(count), 32'd3);
    flush  = 1'b1;
    if_pc  = 32'h00400BAD;
    #1;
    chk("flush_validto", 32'(id_exe_validto), 32'h0);
    step();
    flush      = 1'b0;
    if_validto = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    step();
    chk("flush_not_stored", 32'(count), 32'd0);

    // Randomized traffic checked by the model.
    for (int c = 0; c < 2000; c++) begin
      if_validto  = ($urandom_range(0, 3) != 0);
      if_pc       = $urandom;
      if_instr    = {6'h0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      exe_allowin = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 31) == 0);
      rs_rf       = $urandom;
      rt_rf       = $urandom;
      for (int i = 0; i < NFWD; i++) begin
        fwd_valid[i]         = $urandom_range(0, 1) != 0;
        fwd_pending[i]       = ($urandom_range(0, 3) == 0);
        fwd_rdc[5*i +: 5]    = 5'($urandom_range(0, 3));
        fwd_data[32*i +: 32] = $urandom;
      end
      step();
    end
    idle_inputs();
    chk("stall_cnt_sat", 32'(stall_cnt), 32'hF);

    // Mid-cycle asynchronous reset while stalled with 2 entries.
    flush = 1'b1;
    step();
    flush       = 1'b0;
    fwd_valid   = 3'b001;
    fwd_rdc     = {5'd0, 5'd0, 5'd4};
    fwd_pending = 3'b001;
    exe_allowin = 1'b1;
    if_validto  = 1'b1;
    if_pc       = 32'h00400400;
    if_instr    = 32'h00800020;
    step();
    if_pc    = 32'h00400404;
    if_instr = 32'h00000020;
    step();
    if_validto = 1'b0;
    #1;
    chk("prerst_count", 32'(count), 32'd2);
    chk("prerst_stall", 32'(stall), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_count",    32'(count), 32'd0);
    chk("arst_stallcnt", 32'(stall_cnt), 32'd0);
    chk("arst_pc",       pc_out, 32'h0);
    chk("arst_instr",    instr_out, 32'h0);
    chk("arst_allowin",  32'(id_allowin), 32'h1);
    chk("arst_validto",  32'(id_exe_validto), 32'h0);
    idle_inputs();
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_id_buf.md
# pipe_id_buf

Parametrised decode-front stage for the MIPS pipeline. It replaces the single ID pipe register with a DEPTH-entry instruction buffer between IF and ID, so IF can keep fetching while ID stalls. At the buffer head it generalises operand forwarding to NFWD prioritised bypass sources, and it detects not-yet-available producers (load/mfc0 style) to raise a stall. It keeps the valid/allowin handshake with IF and EXE, and supports a single-cycle flush and a saturating stall-cycle counter.

## Interface
Parameters:
- DEPTH, 4, buffer entries; power of two, ≥2
- NFWD, 3, number of bypass sources; index 0 = youngest stage = highest priority
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_validto  in  1  IF offers {if_pc, if_instr}
- if_pc  in  32  fetched PC
- if_instr  in  32  fetched instruction
- id_allowin  out  1  buffer accepts a push this cycle
- exe_allowin  in  1  EXE accepts the head this cycle
- id_exe_validto  out  1  head is valid, ready and not flushed
- flush  in  1  discard all buffered and incoming entries
- rsc, rtc  out  5 each  head instr[25:21], instr[20:16]; go to regfile read ports
- rs_rf, rt_rf  in  32 each  regfile read data
- fwd_valid  in  NFWD  source i writes a register
- fwd_pending  in  NFWD  source i's result is not yet available
- fwd_rdc  in  5*NFWD  destination of source i, packed at [5i+4:5i]
- fwd_data  in  32*NFWD  result of source i, packed at [32i+31:32i]
- pc_out, instr_out  out  32 each  head entry
- rs_out, rt_out  out  32 each  forwarded operands
- stall  out  1  head is blocked by a pending producer
- count  out  $clog2(DEPTH+1)  occupancy
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
Buffer:
- Circular FIFO of {pc, instr}, with wr_ptr, rd_ptr and count.
- push = if_validto & id_allowin & !flush.
- pop = head_valid & !stall & exe_allowin & !flush.
- head_valid = (count != 0).
- id_allowin = (count < DEPTH) | pop. This is combinational through exe_allowin, matching the existing handshake.
- id_exe_validto = head_valid & !stall & !flush.
- If the buffer is empty, pc_out, instr_out, rs_out and rt_out keep showing the last storage contents. Only id_exe_validto qualifies them.

Forwarding, evaluated independently for rs and rt:
- A source i matches when fwd_valid[i] & fwd_rdc_i != 0 & fwd_rdc_i == rsc (or rtc).
- The lowest-index matching source wins. Lower-priority matches are ignored, even if they are pending.
- Winner with pending = 0: the operand is fwd_data_i.
- Winner with pending = 1: hazard.
- No match: the operand is rs_rf / rt_rf.
- Register 0 never matches. rs_out and rt_out are 0 when rsc and rtc are 0 respectively.
- stall = head_valid & (hazard_rs | hazard_rt).

Flush:
- On the next edge, wr_ptr, rd_ptr and count are set to 0.
- A push or pop requested in the same cycle is discarded.

Stall counter:
- Increments by 1 on every edge where stall = 1.
- Holds at 2^CNT_W-1 once saturated.
- Cleared only by reset.

## Timing
- Reset (rst_n low, asynchronous) sets pointers, count and stall_cnt to 0 and clears storage to 0. Consequently:
  - id_exe_validto = 0, stall = 0, id_allowin = 1.
  - pc_out = instr_out = 0, rsc = rtc = 0, rs_out = rt_out = 0.
- Push-to-head latency is 1 cycle: an entry written at edge k is visible as the head after edge k. There is no same-cycle pass-through when empty.
- All outputs except count and stall_cnt are combinational from the head entry and the current bypass inputs. Forwarding and stall therefore track EXE/MEM/WB in the same cycle.
- Full with pop in the same cycle: the push is accepted and count is unchanged.
- Full with no pop: id_allowin = 0 and IF must hold its offer.
- Push and pop in the same cycle at count = 1: count stays 1 and the new entry becomes the head.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Reset asserted mid-stream aborts immediately. Nothing survives, and no output glitches to valid.

## Test plan
- Reset, then 5 back-to-back pushes (pc 0x00400000 + 4n) with exe_allowin = 0, DEPTH = 4 → count = 4; id_allowin drops after the 4th push; the 5th offer is held. After exe_allowin = 1, the entries drain in order, one per cycle.
- Head `add $3,$1,$2`; source 0 (rdc = 1, data 0x11) and source 2 (rdc = 1, data 0x22) both valid, not pending; rt_rf = 0x5 → rs_out = 0x11, rt_out = 0x5, id_exe_validto = 1.
- Head reads $4; source 0 has rdc = 4, pending = 1 for 2 cycles, then data 0x99 with pending = 0 → stall = 1 and id_exe_validto = 0 for 2 cycles; stall_cnt = 2; then rs_out = 0x99 and the entry pops.
- Head reads $0; source 0 has rdc = 0, valid, pending → no stall, rs_out = 0.
- Buffer holding 3 entries; flush asserted with if_validto = 1 → id_exe_validto = 0 in that cycle; count = 0 after the edge; the offered instruction is not stored.
- rst_n pulsed low mid-cycle while count = 2 and stall = 1 → count, stall_cnt, pc_out and instr_out read 0 immediately, and id_allowin = 1.
